// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one immediate-extension unit between decode (req0)
// and branch-target (req1), with a one-entry valid/ready output register.
module ext_arbiter #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  input  logic [IN_W-1:0]   req0_data_i,
  input  logic [1:0]        req0_mode_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [IN_W-1:0]   req1_data_i,
  input  logic [1:0]        req1_mode_i,
  output logic              req1_ready_o,
  output logic              ext_valid_o,
  output logic [OUT_W-1:0]  ext_data_o,
  output logic              ext_id_o,
  input  logic              ext_ready_i
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg, last_grant_next;
  logic [OUT_W-1:0] data_reg, data_next;
  logic             id_reg, id_next;

  logic             can_accept;
  logic             grant0, grant1, accept;
  logic [IN_W-1:0]  sel_data;
  logic [1:0]       sel_mode;
  logic [OUT_W-1:0] ext_value;

  // Readies are suppressed during reset so no handshake completes in that cycle.
  always_comb begin
    can_accept = !rst_i && ((state_reg == EMPTY) || ((state_reg == FULL) && ext_ready_i));
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_accept) begin
      if (req0_valid_i && req1_valid_i) begin
        grant0 = last_grant_reg;
        grant1 = !last_grant_reg;
      end else begin
        grant0 = req0_valid_i;
        grant1 = req1_valid_i;
      end
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign accept       = (grant0 && req0_valid_i) || (grant1 && req1_valid_i);
  assign sel_data     = grant1 ? req1_data_i : req0_data_i;
  assign sel_mode     = grant1 ? req1_mode_i : req0_mode_i;

  always_comb begin
    ext_value = '0;
    case (sel_mode)
      2'b00: ext_value = {{IN_W{sel_data[IN_W-1]}}, sel_data};
      2'b01: ext_value = {{IN_W{1'b0}}, sel_data};
      2'b10: ext_value = {sel_data, {IN_W{1'b0}}};
      default: ext_value = {{(IN_W-2){sel_data[IN_W-1]}}, sel_data, 2'b00};
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    data_next       = data_reg;
    id_next         = id_reg;
    if (accept) begin
      state_next      = FULL;
      data_next       = ext_value;
      id_next         = grant1;
      last_grant_next = grant1;
    end else if ((state_reg == FULL) && ext_ready_i) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= EMPTY;
      last_grant_reg <= 1'b1;
      data_reg       <= '0;
      id_reg         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      data_reg       <= data_next;
      id_reg         <= id_next;
    end
  end

  assign ext_valid_o = (state_reg == FULL);
  assign ext_data_o  = data_reg;
  assign ext_id_o    = id_reg;

endmodule

// File: tb/tb_ext_arbiter.sv
// Self-checking bench for ext_arbiter: directed test-plan steps followed by
// randomized protocol-respecting traffic compared against a behavioural model.
module tb_ext_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic [15:0] req0_data_i, req1_data_i;
  logic [1:0]  req0_mode_i, req1_mode_i;
  logic        req0_ready_o, req1_ready_o;
  logic        ext_valid_o;
  logic [31:0] ext_data_o;
  logic        ext_id_o;
  logic        ext_ready_i;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Behavioural model of the output slot and arbitration history
  bit          m_held;
  logic [31:0] m_data;
  bit          m_id;
  bit          m_last;

  ext_arbiter #(.IN_W(16), .OUT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_mode_i(req0_mode_i),
    .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_mode_i(req1_mode_i),
    .req1_ready_o(req1_ready_o),
    .ext_valid_o(ext_valid_o), .ext_data_o(ext_data_o), .ext_id_o(ext_id_o),
    .ext_ready_i(ext_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] extend(input logic [15:0] d, input logic [1:0] m);
    logic signed [31:0] s;
    s = $signed(d);
    case (m)
      2'd0: return s;
      2'd1: return 32'(d);
      2'd2: return 32'(d) << 16;
      default: return s * 4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check pre-edge view against the model, clock, update model.
  task automatic step(input bit rst, input bit v0, input logic [15:0] d0, input logic [1:0] m0,
                      input bit v1, input logic [15:0] d1, input logic [1:0] m1, input bit er,
                      output bit acc0, output bit acc1);
    bit can, g0, g1;
    rst_i = rst; ext_ready_i = er;
    req0_valid_i = v0; req0_data_i = d0; req0_mode_i = m0;
    req1_valid_i = v1; req1_data_i = d1; req1_mode_i = m1;
    #2;
    can = !rst && (!m_held || er);
    g0 = can && v0 && (!v1 || m_last == 1'b1);
    g1 = can && v1 && (!v0 || m_last == 1'b0);
    chk("req0_ready", 32'(req0_ready_o), 32'(g0));
    chk("req1_ready", 32'(req1_ready_o), 32'(g1));
    chk("ext_valid", 32'(ext_valid_o), 32'(m_held));
    chk("ext_data", ext_data_o, m_data);
    chk("ext_id", 32'(ext_id_o), 32'(m_id));
    acc0 = g0;
    acc1 = g1;
    $display("cycle rst=%0b v=%0b%0b er=%0b grant=%0b%0b out_v=%0b data=%h id=%0b",
             rst, v0, v1, er, g0, g1, ext_valid_o, ext_data_o, ext_id_o);
    @(posedge clk_i);
    if (rst) begin
      m_held = 0; m_data = '0; m_id = 0; m_last = 1;
    end else if (g0 || g1) begin
      m_held = 1; m_id = g1; m_last = g1;
      m_data = g1 ? extend(d1, m1) : extend(d0, m0);
    end else if (m_held && er) begin
      m_held = 0;
    end
    #1;
  endtask

  initial begin
    bit a0, a1;
    bit p0, p1;
    logic [15:0] pd0, pd1;
    logic [1:0]  pm0, pm1;

    rst_i = 1; ext_ready_i = 0;
    req0_valid_i = 0; req0_data_i = '0; req0_mode_i = '0;
    req1_valid_i = 0; req1_data_i = '0; req1_mode_i = '0;
    @(posedge clk_i); #1;
    m_held = 0; m_data = '0; m_id = 0; m_last = 1;

    step(1, 0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 0, a0, a1);
    chk("reset_valid", 32'(ext_valid_o), 32'd0);

    // Sign extension on req0
    step(0, 1, 16'h8001, 2'd0, 0, 16'h0, 2'd0, 1, a0, a1);
    chk("tp1_data", ext_data_o, 32'hFFFF8001);
    chk("tp1_id", 32'(ext_id_o), 32'd0);

    // Mode sweep on req1
    step(0, 0, 16'h0, 2'd0, 1, 16'h8004, 2'd1, 1, a0, a1);
    chk("sweep_zero", ext_data_o, 32'h00008004);
    step(0, 0, 16'h0, 2'd0, 1, 16'h8004, 2'd2, 1, a0, a1);
    chk("sweep_upper", ext_data_o, 32'h80040000);
    step(0, 0, 16'h0, 2'd0, 1, 16'h8004, 2'd3, 1, a0, a1);
    chk("sweep_branch", ext_data_o, 32'hFFFE0010);
    chk("sweep_id", 32'(ext_id_o), 32'd1);

    // Continuous contention alternates 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'h0010 + 16'(i), 2'd1, 1, 16'h0020 + 16'(i), 2'd1, 1, a0, a1);
      chk("rr_id", 32'(ext_id_o), 32'(i % 2));
    end

    // Backpressure holds the slot; release grants req0 next
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'h0100, 2'd1, 1, 16'h0200, 2'd1, 0, a0, a1);
      chk("bp_data", ext_data_o, 32'h00000023);
    end
    step(0, 1, 16'h0100, 2'd1, 1, 16'h0200, 2'd1, 1, a0, a1);
    chk("bp_release_id", 32'(ext_id_o), 32'd0);
    chk("bp_release_data", ext_data_o, 32'h00000100);

    // Reset while FULL, then contention favours req0
    step(1, 0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 0, a0, a1);
    chk("rst_full_valid", 32'(ext_valid_o), 32'd0);
    chk("rst_full_data", ext_data_o, 32'd0);
    step(0, 1, 16'h7FFF, 2'd3, 1, 16'h1234, 2'd0, 1, a0, a1);
    chk("post_rst_id", 32'(ext_id_o), 32'd0);

    // Randomized traffic; requesters hold their request until accepted
    p0 = 0; p1 = 0; pd0 = '0; pd1 = '0; pm0 = '0; pm1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(1, 0) == 1) begin
        p0 = 1; pd0 = 16'($urandom); pm0 = 2'($urandom);
      end
      if (!p1 && $urandom_range(1, 0) == 1) begin
        p1 = 1; pd1 = 16'($urandom); pm1 = 2'($urandom);
      end
      step($urandom_range(49, 0) == 0, p0, pd0, pm0, p1, pd1, pm1,
           $urandom_range(3, 0) != 0, a0, a1);
      if (a0) p0 = 0;
      if (a1) p1 = 0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
